// File: rtl/control_sequencer_if.sv
// Control sequencer bus interface.
//   run, mem_ready, IR      : datapath/host -> sequencer (start, memory data valid, instruction)
//   PCout .. Rout           : one-bit datapath control strobes from the sequencer
//   alu_op                  : ALU operation code (valid in the execute step only)
//   running, halted, illegal: sequencer status
// The master modport is the sequencer side; the slave modport is the datapath side.
interface control_sequencer_if;
  logic        run;
  logic        mem_ready;
  logic [31:0] IR;

  logic        PCout, MARin, IncPC, PCin;
  logic        Read, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic        Gra, Grb, Grc, Rin, Rout;
  logic [4:0]  alu_op;
  logic        running, halted, illegal;

  modport master (
    input  run, mem_ready, IR,
    output PCout, MARin, IncPC, PCin,
    output Read, MDRin, MDRout, IRin,
    output Yin, Zin, Zlowout, Zhighout, HIin, LOin,
    output Gra, Grb, Grc, Rin, Rout,
    output alu_op, running, halted, illegal
  );

  modport slave (
    output run, mem_ready, IR,
    input  PCout, MARin, IncPC, PCin,
    input  Read, MDRin, MDRout, IRin,
    input  Yin, Zin, Zlowout, Zhighout, HIin, LOin,
    input  Gra, Grb, Grc, Rin, Rout,
    input  alu_op, running, halted, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// Control sequencer: steps a single-bus datapath through fetch (T0-T2) and
// execute (T3-T6) for ALU and MUL/DIV instructions, plus nop and halt.
// Ports:
//   clock : system clock, all state changes on its rising edge
//   clear : synchronous active-high reset, overrides every transition
//   bus   : control_sequencer_if.master (run/mem_ready/IR in, control strobes,
//           alu_op and status out)
// Outputs are decoded from the state register and the current IR; the only
// input-dependent strobes are PCin/Zlowout in T1, which follow mem_ready.
module control_sequencer (
  input  logic                       clock,
  input  logic                       clear,
  control_sequencer_if.master        bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_t;

  localparam logic [4:0] OP_ALU_LO = 5'b00011;
  localparam logic [4:0] OP_ALU_HI = 5'b01011;
  localparam logic [4:0] OP_MUL    = 5'b01111;
  localparam logic [4:0] OP_DIV    = 5'b10000;
  localparam logic [4:0] OP_NOP    = 5'b11011;
  localparam logic [4:0] OP_HALT   = 5'b11100;

  state_t     state;
  logic [4:0] opcode;
  logic       is_alu, is_muldiv, is_nop, is_halt, is_exec;
  logic       unused_ir_fields;

  // Register-select fields are consumed by the datapath's register encoder,
  // not by the sequencer.
  assign unused_ir_fields = ^bus.IR[26:0];

  assign opcode    = bus.IR[31:27];
  assign is_alu    = (opcode >= OP_ALU_LO) && (opcode <= OP_ALU_HI);
  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign is_nop    = (opcode == OP_NOP);
  assign is_halt   = (opcode == OP_HALT);
  assign is_exec   = is_alu || is_muldiv;

  // State register. run is only looked at in IDLE and at instruction
  // completion, so dropping it mid-instruction never aborts the instruction.
  // The opcode is resolved in T3 because IR only holds the fetched word after
  // the IRin strobe of T2.
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.run) state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1:   if (bus.mem_ready) state <= S_T2;
        S_T2:   state <= S_T3;
        S_T3: begin
          if (is_exec)      state <= S_T4;
          else if (is_nop)  state <= bus.run ? S_T0 : S_IDLE;
          else if (is_halt) state <= S_HALT;
          else              state <= S_IDLE;
        end
        S_T4:   state <= S_T5;
        S_T5: begin
          if (is_muldiv) state <= S_T6;
          else           state <= bus.run ? S_T0 : S_IDLE;
        end
        S_T6:   state <= bus.run ? S_T0 : S_IDLE;
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode. Only one bus driver (PCout/MDRout/Zlowout/Zhighout/Rout)
  // and at most one of Gra/Grb/Grc is raised in any state.
  always_comb begin
    bus.PCout    = 1'b0;
    bus.MARin    = 1'b0;
    bus.IncPC    = 1'b0;
    bus.PCin     = 1'b0;
    bus.Read     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zin      = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.Gra      = 1'b0;
    bus.Grb      = 1'b0;
    bus.Grc      = 1'b0;
    bus.Rin      = 1'b0;
    bus.Rout     = 1'b0;
    bus.alu_op   = 5'b00000;
    bus.running  = 1'b0;
    bus.halted   = 1'b0;
    bus.illegal  = 1'b0;

    case (state)
      S_T0: begin
        bus.PCout   = 1'b1;
        bus.MARin   = 1'b1;
        bus.IncPC   = 1'b1;
        bus.Zin     = 1'b1;
        bus.running = 1'b1;
      end
      S_T1: begin
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
        bus.running = 1'b1;
        // Incremented PC is written back only in the cycle the read completes.
        if (bus.mem_ready) begin
          bus.Zlowout = 1'b1;
          bus.PCin    = 1'b1;
        end
      end
      S_T2: begin
        bus.MDRout  = 1'b1;
        bus.IRin    = 1'b1;
        bus.running = 1'b1;
      end
      S_T3: begin
        // nop/halt resolve here with every output low; anything else that is
        // not executable is flagged for exactly this one cycle.
        if (is_exec) begin
          bus.Grb     = 1'b1;
          bus.Rout    = 1'b1;
          bus.Yin     = 1'b1;
          bus.running = 1'b1;
        end else if (!is_nop && !is_halt) begin
          bus.illegal = 1'b1;
        end
      end
      S_T4: begin
        bus.Grc     = 1'b1;
        bus.Rout    = 1'b1;
        bus.Zin     = 1'b1;
        bus.alu_op  = opcode;
        bus.running = 1'b1;
      end
      S_T5: begin
        bus.running = 1'b1;
        if (is_alu) begin
          bus.Zlowout = 1'b1;
          bus.Gra     = 1'b1;
          bus.Rin     = 1'b1;
        end else if (is_muldiv) begin
          bus.Zlowout = 1'b1;
          bus.LOin    = 1'b1;
        end
      end
      S_T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
        bus.running  = 1'b1;
      end
      S_HALT: begin
        bus.halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a directed vector table followed by an opcode
// sweep; expected output words go into a scoreboard queue as each cycle is
// driven and are compared mid-cycle by a separate monitor.
module tb_control_sequencer;

  logic clock;
  logic clear;
  control_sequencer_if bus ();

  control_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output word layout
  localparam logic [26:0] PCOUT    = 27'(1) << 26;
  localparam logic [26:0] MARIN    = 27'(1) << 25;
  localparam logic [26:0] INCPC    = 27'(1) << 24;
  localparam logic [26:0] PCIN     = 27'(1) << 23;
  localparam logic [26:0] READ     = 27'(1) << 22;
  localparam logic [26:0] MDRIN    = 27'(1) << 21;
  localparam logic [26:0] MDROUT   = 27'(1) << 20;
  localparam logic [26:0] IRIN     = 27'(1) << 19;
  localparam logic [26:0] YIN      = 27'(1) << 18;
  localparam logic [26:0] ZIN      = 27'(1) << 17;
  localparam logic [26:0] ZLOW     = 27'(1) << 16;
  localparam logic [26:0] ZHIGH    = 27'(1) << 15;
  localparam logic [26:0] HIIN     = 27'(1) << 14;
  localparam logic [26:0] LOIN     = 27'(1) << 13;
  localparam logic [26:0] GRA      = 27'(1) << 12;
  localparam logic [26:0] GRB      = 27'(1) << 11;
  localparam logic [26:0] GRC      = 27'(1) << 10;
  localparam logic [26:0] RIN      = 27'(1) << 9;
  localparam logic [26:0] ROUT     = 27'(1) << 8;
  localparam logic [26:0] RUNNING  = 27'(1) << 2;
  localparam logic [26:0] HALTED   = 27'(1) << 1;
  localparam logic [26:0] ILLEGAL  = 27'(1) << 0;

  localparam logic [26:0] E_OFF  = 27'h0;
  localparam logic [26:0] E_T0   = PCOUT | MARIN | INCPC | ZIN | RUNNING;
  localparam logic [26:0] E_T1W  = READ | MDRIN | RUNNING;
  localparam logic [26:0] E_T1R  = READ | MDRIN | ZLOW | PCIN | RUNNING;
  localparam logic [26:0] E_T2   = MDROUT | IRIN | RUNNING;
  localparam logic [26:0] E_T3   = GRB | ROUT | YIN | RUNNING;
  localparam logic [26:0] E_T5A  = ZLOW | GRA | RIN | RUNNING;
  localparam logic [26:0] E_T5M  = ZLOW | LOIN | RUNNING;
  localparam logic [26:0] E_T6   = ZHIGH | HIIN | RUNNING;
  localparam logic [26:0] E_HALT = HALTED;
  localparam logic [26:0] E_ILL  = ILLEGAL;

  localparam logic [31:0] IR_ADD  = 32'h1A1B8000;
  localparam logic [31:0] IR_MUL  = 32'h781B8000;
  localparam logic [31:0] IR_NOP  = 32'hD8000000;
  localparam logic [31:0] IR_HALT = 32'hE0000000;
  localparam logic [31:0] IR_BAD  = 32'hF8000000;

  function automatic logic [26:0] e_t4(input logic [4:0] op);
    return GRC | ROUT | ZIN | RUNNING | (27'(op) << 3);
  endfunction

  function automatic logic [26:0] got();
    return {bus.PCout, bus.MARin, bus.IncPC, bus.PCin, bus.Read, bus.MDRin,
            bus.MDRout, bus.IRin, bus.Yin, bus.Zin, bus.Zlowout, bus.Zhighout,
            bus.HIin, bus.LOin, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout,
            bus.alu_op, bus.running, bus.halted, bus.illegal};
  endfunction

  typedef struct {
    string       name;
    logic [26:0] exp;
  } sb_t;

  typedef struct {
    string       name;
    logic        clr;
    logic        run;
    logic        mr;
    logic [31:0] ir;
    logic [26:0] exp;
  } vec_t;

  sb_t  sb[$];
  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;
  logic chk_en = 1'b0;
  sb_t  cur;

  // Drive one cycle's inputs; exp is what the outputs must be during this cycle.
  task automatic cyc(input string nm, input logic c, input logic r, input logic m,
                     input logic [31:0] ir, input logic [26:0] exp);
    @(negedge clock);
    clear         = c;
    bus.run       = r;
    bus.mem_ready = m;
    bus.IR        = ir;
    sb.push_back('{name: nm, exp: exp});
  endtask

  function automatic void add(input string nm, input logic c, input logic r, input logic m,
                              input logic [31:0] ir, input logic [26:0] exp);
    tbl.push_back('{name: nm, clr: c, run: r, mr: m, ir: ir, exp: exp});
  endfunction

  // Scoreboard monitor: compares mid-cycle, well away from the rising edge.
  always @(negedge clock) begin
    #3;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      tests++;
      if (got() !== cur.exp) begin
        fails++;
        $display("FAIL %s: got %h expected %h", cur.name, got(), cur.exp);
      end
    end
  end

  // Bus-driver and register-select exclusivity, every cycle.
  always @(posedge clock) begin
    if (chk_en) begin
      tests++;
      if ($countones({bus.PCout, bus.MDRout, bus.Zlowout, bus.Zhighout, bus.Rout}) > 1 ||
          $countones({bus.Gra, bus.Grb, bus.Grc}) > 1 || (bus.Rin && bus.Rout)) begin
        fails++;
        $display("FAIL exclusivity: drivers %b selects %b rin/rout %b%b required at most one each",
                 {bus.PCout, bus.MDRout, bus.Zlowout, bus.Zhighout, bus.Rout},
                 {bus.Gra, bus.Grb, bus.Grc}, bus.Rin, bus.Rout);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  op;
    logic [31:0] ir;
    int          guard;

    // ---- directed vector table: {clear, run, mem_ready, IR, expected} ----
    add("reset_idle",   0, 0, 1, IR_ADD, E_OFF);
    add("idle_hold",    0, 0, 1, IR_ADD, E_OFF);
    add("idle_start",   0, 1, 1, IR_ADD, E_OFF);
    add("add_t0",       0, 1, 1, IR_ADD, E_T0);
    add("add_t1",       0, 1, 1, IR_ADD, E_T1R);
    add("add_t2",       0, 1, 1, IR_ADD, E_T2);
    add("add_t3",       0, 1, 1, IR_ADD, E_T3);
    add("add_t4",       0, 1, 1, IR_ADD, e_t4(5'b00011));
    add("add_t5",       0, 0, 1, IR_ADD, E_T5A);
    add("add_done",     0, 0, 1, IR_ADD, E_OFF);
    add("mul_start",    0, 1, 1, IR_MUL, E_OFF);
    add("mul_t0",       0, 0, 1, IR_MUL, E_T0);
    add("mul_t1",       0, 0, 1, IR_MUL, E_T1R);
    add("mul_t2",       0, 0, 1, IR_MUL, E_T2);
    add("mul_t3",       0, 0, 1, IR_MUL, E_T3);
    add("mul_t4",       0, 0, 1, IR_MUL, e_t4(5'b01111));
    add("mul_t5",       0, 0, 1, IR_MUL, E_T5M);
    add("mul_t6",       0, 1, 1, IR_MUL, E_T6);
    add("nop_t0",       0, 1, 1, IR_NOP, E_T0);
    add("nop_t1",       0, 1, 1, IR_NOP, E_T1R);
    add("nop_t2",       0, 1, 1, IR_NOP, E_T2);
    add("nop_t3",       0, 0, 1, IR_NOP, E_OFF);
    add("nop_done",     0, 0, 1, IR_NOP, E_OFF);
    add("wait_start",   0, 1, 1, IR_ADD, E_OFF);
    add("wait_t0",      0, 1, 0, IR_ADD, E_T0);
    add("wait_t1_a",    0, 1, 0, IR_ADD, E_T1W);
    add("wait_t1_b",    0, 1, 0, IR_ADD, E_T1W);
    add("wait_t1_c",    0, 1, 0, IR_ADD, E_T1W);
    add("wait_t1_rdy",  0, 1, 1, IR_ADD, E_T1R);
    add("wait_t2",      0, 1, 1, IR_ADD, E_T2);
    add("wait_t3",      0, 1, 1, IR_ADD, E_T3);
    add("wait_t4",      0, 1, 1, IR_ADD, e_t4(5'b00011));
    add("wait_t5",      0, 1, 1, IR_ADD, E_T5A);
    add("rst4_t0",      0, 0, 1, IR_ADD, E_T0);
    add("rst4_t1",      0, 0, 1, IR_ADD, E_T1R);
    add("rst4_t2",      0, 0, 1, IR_ADD, E_T2);
    add("rst4_t3",      0, 0, 1, IR_ADD, E_T3);
    add("rst4_t4_clr",  1, 1, 1, IR_ADD, e_t4(5'b00011));
    add("rst4_idle_a",  0, 0, 1, IR_ADD, E_OFF);
    add("rst4_idle_b",  0, 0, 1, IR_ADD, E_OFF);
    add("rst4_idle_c",  0, 0, 1, IR_ADD, E_OFF);
    add("halt_start",   0, 1, 1, IR_HALT, E_OFF);
    add("halt_t0",      0, 1, 1, IR_HALT, E_T0);
    add("halt_t1",      0, 1, 1, IR_HALT, E_T1R);
    add("halt_t2",      0, 1, 1, IR_HALT, E_T2);
    add("halt_t3",      0, 1, 1, IR_HALT, E_OFF);
    add("halt_a",       0, 0, 1, IR_HALT, E_HALT);
    add("halt_b",       0, 1, 1, IR_HALT, E_HALT);
    add("halt_c",       0, 0, 1, IR_HALT, E_HALT);
    add("halt_clr",     1, 1, 1, IR_HALT, E_HALT);
    add("halt_cleared", 0, 0, 1, IR_HALT, E_OFF);
    add("ill_start",    0, 1, 1, IR_BAD, E_OFF);
    add("ill_t0",       0, 1, 1, IR_BAD, E_T0);
    add("ill_t1",       0, 1, 1, IR_BAD, E_T1R);
    add("ill_t2",       0, 1, 1, IR_BAD, E_T2);
    add("ill_t3",       0, 1, 1, IR_BAD, E_ILL);
    add("ill_idle_a",   0, 0, 1, IR_BAD, E_OFF);
    add("ill_idle_b",   0, 0, 1, IR_BAD, E_OFF);
    add("t1clr_start",  0, 1, 0, IR_ADD, E_OFF);
    add("t1clr_t0",     0, 1, 0, IR_ADD, E_T0);
    add("t1clr_t1",     1, 1, 0, IR_ADD, E_T1W);
    add("t1clr_idle",   0, 0, 0, IR_ADD, E_OFF);

    clear         = 1'b1;
    bus.run       = 1'b1;
    bus.mem_ready = 1'b1;
    bus.IR        = IR_ADD;
    repeat (2) @(posedge clock);
    chk_en = 1'b1;

    foreach (tbl[i])
      cyc(tbl[i].name, tbl[i].clr, tbl[i].run, tbl[i].mr, tbl[i].ir, tbl[i].exp);

    // ---- opcode sweep: class boundaries for every 5-bit opcode ----
    for (int k = 0; k < 32; k++) begin
      op = 5'(k);
      ir = {op, 27'h01B8000};
      cyc("sw_start", 0, 1, 1, ir, E_OFF);
      cyc("sw_t0",    0, 0, 1, ir, E_T0);
      cyc("sw_t1",    0, 0, 1, ir, E_T1R);
      cyc("sw_t2",    0, 0, 1, ir, E_T2);
      if ((k >= 3 && k <= 11) || k == 15 || k == 16) begin
        cyc("sw_t3", 0, 0, 1, ir, E_T3);
        cyc("sw_t4", 0, 0, 1, ir, e_t4(op));
        if (k == 15 || k == 16) begin
          cyc("sw_t5m", 0, 0, 1, ir, E_T5M);
          cyc("sw_t6",  0, 0, 1, ir, E_T6);
        end else begin
          cyc("sw_t5a", 0, 0, 1, ir, E_T5A);
        end
      end else if (k == 27) begin
        cyc("sw_nop", 0, 0, 1, ir, E_OFF);
      end else if (k == 28) begin
        cyc("sw_halt",     0, 0, 1, ir, E_OFF);
        cyc("sw_halt_run", 0, 1, 1, ir, E_HALT);
        cyc("sw_halt_clr", 1, 1, 1, ir, E_HALT);
      end else begin
        cyc("sw_illegal", 0, 0, 1, ir, E_ILL);
      end
      cyc("sw_idle", 0, 0, 1, ir, E_OFF);
    end

    // Drain the scoreboard, bounded.
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    #5;
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
